multi_product_vending_ctrl: RTL and testbench
=============================================

MULTI_PRODUCT_VENDING_CTRL -- requirements
Module: multi_product_vending_ctrl

Interface
REQ-001 SHALL have parameter VAL_W, default 8, the width of coin, credit, price and change values.
REQ-002 SHALL have parameter N_PROD, default 4, the number of selectable products (>=2).
REQ-003 SHALL have parameter SALES_W, default 16, the width of the total_sales accumulator.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1000, the inactivity refund limit in cycles (used only with VEND_TIMEOUT_EN).
REQ-005 SHALL have ports, one clock and one reset, with the reset asynchronous and active-low:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- coin_valid  in  1  one-cycle coin-insert pulse
- coin_value  in  VAL_W  value of the inserted coin
- sel_valid  in  1  product-select request, level
- sel_idx  in  $clog2(N_PROD)  selected product
- cancel  in  1  refund request, pulse
- price_table  in  N_PROD*VAL_W  flat price bus; product i occupies bits [i*VAL_W +: VAL_W]
- credit  out  VAL_W  current credit
- coin_reject  out  1  one-cycle pulse: coin not accepted
- vend_valid / vend_idx / vend_ready  out / out / in  1 / $clog2(N_PROD) / 1  dispense handshake
- change_valid / change_value / change_ready  out / out / in  1 / VAL_W / 1  change handshake
- alarm  out  1  insufficient credit or invalid selection
- state  out  3  FSM state code
- total_sales  out  SALES_W  accumulated sales

Function
REQ-006 SHALL implement the states IDLE=0, CREDIT=1, VEND=2, CHANGE=3 and ERROR=4.
REQ-007 IDLE SHALL, on coin_valid with coin_value!=0, set credit=coin_value and go to CREDIT; a zero coin SHALL be ignored.
REQ-008 CREDIT SHALL, on coin_valid, add coin_value to credit; a sum exceeding 2^VAL_W-1 SHALL leave credit unchanged and pulse coin_reject.
REQ-009 CREDIT SHALL, on sel_valid, sample the price P of sel_idx from price_table and act as follows:
- credit>=P: credit-=P, total_sales+=P (wraps mod 2^SALES_W), go to VEND.
- otherwise, or sel_idx>=N_PROD: alarm=1, go to ERROR.
REQ-010 CREDIT priority SHALL be cancel > sel_valid > coin_valid; a coin not processed because of a higher-priority event SHALL pulse coin_reject.
REQ-011 CREDIT SHALL, on cancel, go to CHANGE if credit>0, else to IDLE.
REQ-012 VEND SHALL hold vend_valid=1 with vend_idx stable until the cycle with vend_ready=1, then go to CHANGE if credit>0, else to IDLE.
REQ-013 CHANGE SHALL hold change_valid=1 with change_value=credit until change_ready=1, then clear credit and go to IDLE.
REQ-014 ERROR SHALL hold alarm=1 while sel_valid=1, then clear alarm and return to CREDIT with credit unchanged; cancel in ERROR SHALL clear alarm and go to CHANGE.
REQ-015 In VEND, CHANGE and ERROR, any coin_valid SHALL pulse coin_reject the following cycle and not change credit.
REQ-016 All outputs SHALL be registered; coin_reject SHALL assert exactly one cycle after the rejected coin_valid.

Reset
REQ-017 Asserting rst_n low at any time, including mid-handshake, SHALL force state=IDLE and clear credit, total_sales, alarm, coin_reject, vend_valid, vend_idx, change_valid and change_value to 0; credit held at that moment SHALL be lost.

Configuration
REQ-018 With VEND_TIMEOUT_EN defined, CREDIT SHALL count consecutive cycles with no coin_valid, sel_valid or cancel; on reaching TIMEOUT_CYC it SHALL go to CHANGE (a refund). Any such event SHALL reset the count.
REQ-019 Without VEND_TIMEOUT_EN, no counter SHALL exist and credit SHALL be held indefinitely.

Structure
REQ-020 Package vend_pkg SHALL hold the state enum, the state width and the state encodings.
REQ-021 The inactivity counter SHALL be the sub-module vend_timeout_timer, instantiated only under VEND_TIMEOUT_EN.

Verification
REQ-022 The bench SHALL cover the following scenarios (default parameters, prices {50,75,100,120}):
- Coins 25,25,50; select 2 -> VEND with vend_idx=2; credit=0; total_sales=100; then IDLE without entering CHANGE.
- Coins 100,50; select 1 -> after vend_ready, change_value=75 with change_valid held for 3 stalled cycles, then credit=0 and IDLE.
- Coin 25; select 0 -> alarm=1 in ERROR; sel_valid released -> CREDIT with credit=25; cancel -> change_value=25.
- credit=200; coin 100 -> coin_reject pulse and credit stays 200; coin during VEND -> coin_reject.
- Reset asserted while change_valid=1 -> all outputs 0 and state=IDLE asynchronously.
- VEND_TIMEOUT_EN with TIMEOUT_CYC=10: coin 30 then idle 10 cycles -> CHANGE with change_value=30.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the multi-product vending controller: FSM state width and encodings.
package vend_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_CREDIT = 3'd1,
        ST_VEND   = 3'd2,
        ST_CHANGE = 3'd3,
        ST_ERROR  = 3'd4
    } vend_state_e;

endpackage : vend_pkg

// File: rtl/vend_timeout_timer.sv
// Inactivity counter: flags the cycle on which TIMEOUT_CYC consecutive quiet cycles have elapsed.
module vend_timeout_timer #(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count only while enabled and quiet; restart on any activity or on expiry.
    always_comb begin
        expired_c = 1'b0;
        cnt_d     = '0;
        if (en_i && !clr_i) begin
            if (cnt_q == LIMIT) begin
                expired_c = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

endmodule : vend_timeout_timer

// File: rtl/multi_product_vending_ctrl.sv
// Multi-product vending controller: coin credit, product dispense and change handshakes.
// Optional inactivity refund is built when VEND_TIMEOUT_EN is defined.
module multi_product_vending_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned VAL_W       = 8,
    parameter int unsigned N_PROD      = 4,
    parameter int unsigned SALES_W     = 16,
    parameter int unsigned TIMEOUT_CYC = 1000,
    localparam int unsigned IDX_W      = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    coin_valid,
    input  logic [VAL_W-1:0]        coin_value,
    input  logic                    sel_valid,
    input  logic [IDX_W-1:0]        sel_idx,
    input  logic                    cancel,
    input  logic [N_PROD*VAL_W-1:0] price_table,
    output logic [VAL_W-1:0]        credit,
    output logic                    coin_reject,
    output logic                    vend_valid,
    output logic [IDX_W-1:0]        vend_idx,
    input  logic                    vend_ready,
    output logic                    change_valid,
    output logic [VAL_W-1:0]        change_value,
    input  logic                    change_ready,
    output logic                    alarm,
    output logic [STATE_W-1:0]      state,
    output logic [SALES_W-1:0]      total_sales
);

    vend_state_e        state_q, state_d;
    logic [VAL_W-1:0]   credit_q, credit_d;
    logic [SALES_W-1:0] sales_q, sales_d;
    logic               alarm_q, alarm_d;
    logic               coin_reject_q, coin_reject_d;
    logic               vend_valid_q, vend_valid_d;
    logic [IDX_W-1:0]   vend_idx_q, vend_idx_d;
    logic               change_valid_q, change_valid_d;
    logic [VAL_W-1:0]   change_value_q, change_value_d;

    logic [VAL_W-1:0]   price_sel;
    logic               idx_ok;
    logic [VAL_W:0]     coin_sum;
    logic               timeout_hit;

`ifdef VEND_TIMEOUT_EN
    vend_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (state_q == ST_CREDIT),
        .clr_i     (coin_valid | sel_valid | cancel),
        .expired_c (timeout_hit)
    );
`else
    logic timeout_cfg_unused;
    assign timeout_cfg_unused = (TIMEOUT_CYC == 0);
    assign timeout_hit        = 1'b0;
`endif

    // Price lookup; an index beyond the table is flagged rather than read.
    always_comb begin
        price_sel = '0;
        idx_ok    = 1'b0;
        for (int i = 0; i < N_PROD; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                price_sel = price_table[i*VAL_W +: VAL_W];
                idx_ok    = 1'b1;
            end
        end
    end

    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            sales_q        <= '0;
            alarm_q        <= 1'b0;
            coin_reject_q  <= 1'b0;
            vend_valid_q   <= 1'b0;
            vend_idx_q     <= '0;
            change_valid_q <= 1'b0;
            change_value_q <= '0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            sales_q        <= sales_d;
            alarm_q        <= alarm_d;
            coin_reject_q  <= coin_reject_d;
            vend_valid_q   <= vend_valid_d;
            vend_idx_q     <= vend_idx_d;
            change_valid_q <= change_valid_d;
            change_value_q <= change_value_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        sales_d        = sales_q;
        vend_idx_d     = vend_idx_q;
        coin_reject_d  = 1'b0;
        alarm_d        = 1'b0;
        vend_valid_d   = 1'b0;
        change_valid_d = 1'b0;
        change_value_d = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (coin_valid && coin_value != '0) begin
                    credit_d = coin_value;
                    state_d  = ST_CREDIT;
                end
            end
            // Priority: cancel, then select, then coin; a pre-empted coin is bounced.
            ST_CREDIT: begin
                if (cancel) begin
                    coin_reject_d = coin_valid;
                    state_d       = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                end else if (sel_valid) begin
                    coin_reject_d = coin_valid;
                    if (idx_ok && credit_q >= price_sel) begin
                        credit_d   = credit_q - price_sel;
                        sales_d    = sales_q + SALES_W'(price_sel);
                        vend_idx_d = sel_idx;
                        state_d    = ST_VEND;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else if (coin_valid) begin
                    if (coin_sum[VAL_W]) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = coin_sum[VAL_W-1:0];
                    end
                end else if (timeout_hit) begin
                    state_d = ST_CHANGE;
                end
            end
            ST_VEND: begin
                coin_reject_d = coin_valid;
                if (vend_ready) begin
                    state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                coin_reject_d = coin_valid;
                if (change_ready) begin
                    credit_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            ST_ERROR: begin
                coin_reject_d = coin_valid;
                if (cancel) begin
                    state_d = ST_CHANGE;
                end else if (!sel_valid) begin
                    state_d = ST_CREDIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake and alarm outputs follow the state being entered.
        alarm_d        = (state_d == ST_ERROR);
        vend_valid_d   = (state_d == ST_VEND);
        change_valid_d = (state_d == ST_CHANGE);
        change_value_d = change_valid_d ? credit_d : '0;
    end

    assign state        = state_q;
    assign credit       = credit_q;
    assign total_sales  = sales_q;
    assign alarm        = alarm_q;
    assign coin_reject  = coin_reject_q;
    assign vend_valid   = vend_valid_q;
    assign vend_idx     = vend_idx_q;
    assign change_valid = change_valid_q;
    assign change_value = change_value_q;

endmodule : multi_product_vending_ctrl

// File: tb/tb_multi_product_vending_ctrl.sv
// Directed bench for multi_product_vending_ctrl with scoreboard queues for dispense and change.
// Define VEND_TIMEOUT_EN to exercise the inactivity refund.
module tb_multi_product_vending_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        coin_valid;
    logic [7:0]  coin_value;
    logic        sel_valid;
    logic [1:0]  sel_idx;
    logic        cancel;
    logic [31:0] price_table;
    logic [7:0]  credit;
    logic        coin_reject;
    logic        vend_valid;
    logic [1:0]  vend_idx;
    logic        vend_ready;
    logic        change_valid;
    logic [7:0]  change_value;
    logic        change_ready;
    logic        alarm;
    logic [2:0]  state;
    logic [15:0] total_sales;

    int checks = 0;
    int errors = 0;
    int exp_sales = 0;
    logic [1:0] vend_q[$];
    logic [7:0] change_q[$];

    multi_product_vending_ctrl #(
        .VAL_W       (8),
        .N_PROD      (4),
        .SALES_W     (16),
        .TIMEOUT_CYC (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .sel_valid    (sel_valid),
        .sel_idx      (sel_idx),
        .cancel       (cancel),
        .price_table  (price_table),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .vend_valid   (vend_valid),
        .vend_idx     (vend_idx),
        .vend_ready   (vend_ready),
        .change_valid (change_valid),
        .change_value (change_value),
        .change_ready (change_ready),
        .alarm        (alarm),
        .state        (state),
        .total_sales  (total_sales)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic coin(input logic [7:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        step();
        coin_valid = 1'b0;
        coin_value = '0;
    endtask

    task automatic select(input logic [1:0] idx);
        sel_valid = 1'b1;
        sel_idx   = idx;
        step();
        sel_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_credit"}, 32'(credit), 32'd0);
        chk({tag, "_sales"}, 32'(total_sales), 32'(exp_sales));
        chk({tag, "_vvalid"}, 32'(vend_valid), 32'd0);
        chk({tag, "_cvalid"}, 32'(change_valid), 32'd0);
        chk({tag, "_alarm"}, 32'(alarm), 32'd0);
    endtask

    task automatic expect_vend(input int stall);
        logic [1:0] exp_idx;
        for (int w = 0; w < 8 && !vend_valid; w++) step();
        chk("vend_seen", 32'(vend_valid), 32'd1);
        exp_idx = (vend_q.size() > 0) ? vend_q.pop_front() : 2'bxx;
        for (int s = 0; s < stall; s++) begin
            chk("vend_hold_valid", 32'(vend_valid), 32'd1);
            chk("vend_hold_idx", 32'(vend_idx), 32'(exp_idx));
            step();
        end
        chk("vend_idx", 32'(vend_idx), 32'(exp_idx));
        vend_ready = 1'b1;
        step();
        vend_ready = 1'b0;
        chk("vend_done", 32'(vend_valid), 32'd0);
    endtask

    task automatic expect_change(input int stall);
        logic [7:0] exp_val;
        for (int w = 0; w < 8 && !change_valid; w++) step();
        chk("change_seen", 32'(change_valid), 32'd1);
        exp_val = (change_q.size() > 0) ? change_q.pop_front() : 8'hxx;
        for (int s = 0; s < stall; s++) begin
            chk("change_hold_valid", 32'(change_valid), 32'd1);
            chk("change_hold_value", 32'(change_value), 32'(exp_val));
            step();
        end
        chk("change_value", 32'(change_value), 32'(exp_val));
        change_ready = 1'b1;
        step();
        change_ready = 1'b0;
        check_idle("after_change");
    endtask

    initial begin
        rst_n        = 1'b0;
        coin_valid   = 1'b0;
        coin_value   = '0;
        sel_valid    = 1'b0;
        sel_idx      = '0;
        cancel       = 1'b0;
        vend_ready   = 1'b0;
        change_ready = 1'b0;
        price_table  = {8'd120, 8'd100, 8'd75, 8'd50};
        #2;
        check_idle("reset");
        chk("reset_reject", 32'(coin_reject), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Zero coin in IDLE is ignored.
        coin(8'd0);
        chk("zero_coin_state", 32'(state), 32'd0);
        chk("zero_coin_reject", 32'(coin_reject), 32'd0);

        // Exact payment: 25+25+50, product 2 at 100, no change phase.
        coin(8'd25);
        chk("s1_state_credit", 32'(state), 32'd1);
        coin(8'd25);
        coin(8'd50);
        chk("s1_credit", 32'(credit), 32'd100);
        vend_q.push_back(2'd2);
        exp_sales += 100;
        select(2'd2);
        chk("s1_state_vend", 32'(state), 32'd2);
        chk("s1_credit_after", 32'(credit), 32'd0);
        chk("s1_sales", 32'(total_sales), 32'(exp_sales));
        expect_vend(2);
        check_idle("s1_end");

        // Overpayment: 100+50, product 1 at 75, change 75 with 3 stalled cycles.
        coin(8'd100);
        coin(8'd50);
        chk("s2_credit", 32'(credit), 32'd150);
        vend_q.push_back(2'd1);
        change_q.push_back(8'd75);
        exp_sales += 75;
        select(2'd1);
        chk("s2_credit_after", 32'(credit), 32'd75);
        chk("s2_sales", 32'(total_sales), 32'(exp_sales));
        expect_vend(1);
        chk("s2_state_change", 32'(state), 32'd3);
        expect_change(3);

        // Insufficient credit raises alarm while select is held.
        coin(8'd25);
        sel_valid = 1'b1;
        sel_idx   = 2'd0;
        step();
        chk("s3_state_err", 32'(state), 32'd4);
        chk("s3_alarm", 32'(alarm), 32'd1);
        step();
        chk("s3_alarm_held", 32'(alarm), 32'd1);
        sel_valid = 1'b0;
        step();
        chk("s3_state_credit", 32'(state), 32'd1);
        chk("s3_alarm_clr", 32'(alarm), 32'd0);
        chk("s3_credit", 32'(credit), 32'd25);
        // Cancel wins over a simultaneous coin, which is bounced.
        change_q.push_back(8'd25);
        cancel     = 1'b1;
        coin_valid = 1'b1;
        coin_value = 8'd10;
        step();
        cancel     = 1'b0;
        coin_valid = 1'b0;
        coin_value = '0;
        chk("s3_cancel_reject", 32'(coin_reject), 32'd1);
        chk("s3_state_change", 32'(state), 32'd3);
        expect_change(0);

        // Credit overflow bounces the coin; coin during VEND is bounced too.
        coin(8'd100);
        coin(8'd100);
        chk("s4_credit", 32'(credit), 32'd200);
        coin(8'd100);
        chk("s4_overflow_reject", 32'(coin_reject), 32'd1);
        chk("s4_credit_kept", 32'(credit), 32'd200);
        step();
        chk("s4_reject_pulse", 32'(coin_reject), 32'd0);
        vend_q.push_back(2'd3);
        change_q.push_back(8'd80);
        exp_sales += 120;
        select(2'd3);
        chk("s4_credit_after", 32'(credit), 32'd80);
        chk("s4_sales", 32'(total_sales), 32'(exp_sales));
        coin(8'd10);
        chk("s4_vend_reject", 32'(coin_reject), 32'd1);
        chk("s4_vend_credit", 32'(credit), 32'd80);
        chk("s4_vend_hold", 32'(vend_valid), 32'd1);
        expect_vend(0);
        expect_change(0);

        // Asynchronous reset in the middle of a change handshake.
        coin(8'd40);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("s5_cvalid", 32'(change_valid), 32'd1);
        chk("s5_cvalue", 32'(change_value), 32'd40);
        #3;
        rst_n = 1'b0;
        #1;
        exp_sales = 0;
        check_idle("s5_async");
        chk("s5_cvalue_rst", 32'(change_value), 32'd0);
        chk("s5_vidx_rst", 32'(vend_idx), 32'd0);
        chk("s5_reject_rst", 32'(coin_reject), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check_idle("s5_post");

`ifdef VEND_TIMEOUT_EN
        // Ten quiet cycles in CREDIT trigger a refund.
        coin(8'd30);
        for (int k = 0; k < 9; k++) begin
            step();
            chk("s6_waiting", 32'(state), 32'd1);
        end
        step();
        chk("s6_timeout_state", 32'(state), 32'd3);
        change_q.push_back(8'd30);
        expect_change(0);
`else
        // Without the timeout option credit is held indefinitely.
        coin(8'd30);
        for (int k = 0; k < 30; k++) step();
        chk("s6_hold_state", 32'(state), 32'd1);
        chk("s6_hold_credit", 32'(credit), 32'd30);
        change_q.push_back(8'd30);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        expect_change(0);
`endif

        chk("sb_vend_empty", 32'(vend_q.size()), 32'd0);
        chk("sb_change_empty", 32'(change_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_multi_product_vending_ctrl
